// File: rtl/multiplicador_booth_param.sv
// Iterative radix-4 Booth multiplier, N-bit operands, signed/unsigned chosen per operation.
// Define MULT_ACC_EN to add the acumular port (Y <= Y + product when captured high).
module multiplicador_booth_param #(
  parameter int unsigned N = 8
) (
  input  logic           reloj,
  input  logic           reinicio,
  input  logic           iniciar,
  input  logic           con_signo,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
`ifdef MULT_ACC_EN
  input  logic           acumular,
`endif
  output logic           ocupado,
  output logic           listo,
  output logic [2:0]     Q_LSB,
  output logic [2*N-1:0] Y
);

  localparam int unsigned I  = N / 2 + 1;
  localparam int unsigned W  = N + 2;  // extended operand width, also 2*I multiplier bits
  localparam int unsigned HW = N + 4;  // running sum needs headroom for +-2A
  localparam int unsigned CW = $clog2(I);

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("multiplicador_booth_param: N must be even and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          a_q, a_d;
  logic signed [HW-1:0]  hi_q, hi_d;
  logic [W-1:0]          lo_q, lo_d;
  logic                  qm1_q, qm1_d;
  logic [2*N-1:0]        y_q, y_d;
  logic                  listo_q, listo_d;
`ifdef MULT_ACC_EN
  logic                  acc_q, acc_d;
`endif

  logic [2:0]            trip;
  logic signed [HW-1:0]  a_sx, term, hi_sum;
  logic [2*N-1:0]        prod;

  assign trip   = {lo_q[1:0], qm1_q};
  assign a_sx   = {{2{a_q[W-1]}}, a_q};
  assign hi_sum = hi_q + term;
  assign prod   = (2*N)'({hi_q, lo_q});

  always_comb begin
    term = '0;
    case (trip)
      3'b001, 3'b010: term = a_sx;
      3'b011:         term = a_sx <<< 1;
      3'b100:         term = -(a_sx <<< 1);
      3'b101, 3'b110: term = -a_sx;
      default:        term = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qm1_d   = qm1_q;
    y_d     = y_q;
    listo_d = 1'b0;
`ifdef MULT_ACC_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (iniciar) begin
          state_d = StCalc;
          cnt_d   = '0;
          a_d     = con_signo ? {{2{A[N-1]}}, A} : {2'b00, A};
          lo_d    = con_signo ? {{2{B[N-1]}}, B} : {2'b00, B};
          hi_d    = '0;
          qm1_d   = 1'b0;
`ifdef MULT_ACC_EN
          acc_d   = acumular;
`endif
        end
      end
      StCalc: begin
        // Add the recoded multiple, then shift {hi, lo, q-1} right by two.
        hi_d  = hi_sum >>> 2;
        lo_d  = {hi_sum[1:0], lo_q[W-1:2]};
        qm1_d = lo_q[1];
        if (cnt_q == CW'(I - 1)) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
        listo_d = 1'b1;
`ifdef MULT_ACC_EN
        y_d     = acc_q ? y_q + prod : prod;
`else
        y_d     = prod;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      y_q     <= '0;
      listo_q <= 1'b0;
`ifdef MULT_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      y_q     <= y_d;
      listo_q <= listo_d;
`ifdef MULT_ACC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign ocupado = (state_q != StIdle);
  assign listo   = listo_q;
  assign Q_LSB   = (state_q == StCalc) ? trip : 3'b000;
  assign Y       = y_q;

endmodule

// File: tb/tb_multiplicador_booth_param.sv
// Scoreboard bench for multiplicador_booth_param (N=8): products queued at start, checked on listo.
module tb_multiplicador_booth_param;

  logic        reloj = 1'b0;
  logic        reinicio;
  logic        iniciar;
  logic        con_signo;
  logic [7:0]  a, b;
  logic        acumular;
  logic        ocupado, listo;
  logic [2:0]  q_lsb;
  logic [15:0] y;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 reloj = ~reloj;

  multiplicador_booth_param #(.N(8)) dut (
    .reloj     (reloj),
    .reinicio  (reinicio),
    .iniciar   (iniciar),
    .con_signo (con_signo),
    .A         (a),
    .B         (b),
`ifdef MULT_ACC_EN
    .acumular  (acumular),
`endif
    .ocupado   (ocupado),
    .listo     (listo),
    .Q_LSB     (q_lsb),
    .Y         (y)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] z, input logic s);
    logic [15:0] xe, ze;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ze = s ? {{8{z[7]}}, z} : {8'h00, z};
    return xe * ze;
  endfunction

  // Scoreboard: every listo pulse must match the oldest queued expectation.
  always @(negedge reloj) begin
    if (reinicio && listo) begin
      if (exp_q.size() == 0) check_eq("spurious_listo", 32'd1, 32'd0);
      else check_eq("Y", {16'h0, y}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic start_op(input logic [7:0] x, input logic [7:0] z, input logic s,
                          input logic [15:0] exp);
    a = x; b = z; con_signo = s; iniciar = 1'b1;
    exp_q.push_back(exp);
    @(posedge reloj); #1;
    iniciar = 1'b0;
  endtask

  task automatic wait_listo(input string tag);
    int n = 0;
    while (!listo && n < 20) begin
      @(posedge reloj); #1;
      n++;
    end
    check_eq(tag, n, 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] trips [5];
    int seen;
    reinicio = 1'b0; iniciar = 1'b0; con_signo = 1'b0; a = '0; b = '0; acumular = 1'b0;
    #3;
    check_eq("rst_ocupado", ocupado, 0);
    check_eq("rst_listo", listo, 0);
    check_eq("rst_qlsb", q_lsb, 0);
    check_eq("rst_y", y, 0);
    @(posedge reloj); #1;
    reinicio = 1'b1;
    @(posedge reloj); #1;

    start_op(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    check_eq("busy_after_start", ocupado, 1);
    wait_listo("lat_unsigned");
    @(posedge reloj); #1;
    check_eq("listo_pulse", listo, 0);
    check_eq("y_hold", y, 16'hFE01);

    start_op(8'h80, 8'h80, 1'b1, 16'h4000);
    wait_listo("lat_s_min");
    @(posedge reloj); #1;
    start_op(8'hFD, 8'h05, 1'b1, 16'hFFF1);
    wait_listo("lat_s_neg");
    @(posedge reloj); #1;

    // Triplets of B=0x06 extended: {1,0,0}, {0,1,1}, then zeros.
    trips = '{3'b100, 3'b011, 3'b000, 3'b000, 3'b000};
    start_op(8'h01, 8'h06, 1'b0, 16'h0006);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("qlsb_%0d", i), q_lsb, trips[i]);
      @(posedge reloj); #1;
    end
    check_eq("qlsb_fin", q_lsb, 0);
    check_eq("busy_fin", ocupado, 1);
    @(posedge reloj); #1;
    check_eq("listo_qlsb_op", listo, 1);
    @(posedge reloj); #1;

    // Reset during CALC step 2 discards the operation.
    start_op(8'h12, 8'h34, 1'b0, 16'h03A8);
    @(posedge reloj); #1;
    @(posedge reloj); #1;
    reinicio = 1'b0;
    #1;
    check_eq("midrst_ocupado", ocupado, 0);
    check_eq("midrst_listo", listo, 0);
    check_eq("midrst_y", y, 0);
    check_eq("midrst_qlsb", q_lsb, 0);
    exp_q.delete();
    @(posedge reloj); #1;
    reinicio = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge reloj); #1;
      if (listo) seen++;
    end
    check_eq("no_listo_after_rst", seen, 0);

    // iniciar held high: no restart; operand changes mid-op ignored; b2b accepted on listo.
    a = 8'h05; b = 8'h07; con_signo = 1'b0; iniciar = 1'b1;
    exp_q.push_back(16'h0023);
    @(posedge reloj); #1;
    a = 8'hAA; b = 8'h55; con_signo = 1'b1;
    wait_listo("lat_held");
    a = 8'h00; b = 8'h7B; con_signo = 1'b0;
    exp_q.push_back(16'h0000);
    @(posedge reloj); #1;
    iniciar = 1'b0;
    check_eq("b2b_busy", ocupado, 1);
    wait_listo("lat_b2b");

    // Back-to-back random operations, each started in the previous listo cycle.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] x, z;
      logic s;
      x = 8'($urandom); z = 8'($urandom); s = 1'($urandom);
      start_op(x, z, s, model(x, z, s));
      wait_listo("lat_rand");
    end
    @(posedge reloj); #1;

`ifdef MULT_ACC_EN
    acumular = 1'b0;
    start_op(8'd10, 8'd10, 1'b0, 16'h0064);
    wait_listo("lat_acc0");
    acumular = 1'b1;
    start_op(8'd3, 8'd4, 1'b0, 16'h0070);
    wait_listo("lat_acc1");
    acumular = 1'b0;
    start_op(8'h00, 8'h00, 1'b0, 16'h0000);
    wait_listo("lat_acc_clr");
    acumular = 1'b1;
    start_op(8'hFF, 8'h01, 1'b1, 16'hFFFF);
    wait_listo("lat_acc_s");
    acumular = 1'b0;
    @(posedge reloj); #1;
`endif

    repeat (3) @(posedge reloj);
    #1;
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
